// File: rtl/block_scan_check.sv
// Sequential collision checker: walks the latched block bitmap one cell per clock
// and tests each set cell against the playfield bounds and occupancy bitmap.
module block_scan_check #(
  parameter int FIELD_W    = 20,
  parameter int FIELD_H    = 20,
  parameter int BLK_N      = 4,
  parameter int POS_W      = 5,
  parameter int EARLY_EXIT = 1,
  localparam int CELLS     = BLK_N * BLK_N,
  localparam int IDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [POS_W-1:0]           block_pos_x,
  input  logic [POS_W-1:0]           block_pos_y,
  input  logic [CELLS-1:0]           block_matrix,
  input  logic [FIELD_W*FIELD_H-1:0] field_matrix,
  output logic                       busy,
  output logic                       done,
  output logic                       collide,
  output logic                       hit_oob,
  output logic                       hit_overlap,
  output logic [IDX_W-1:0]           hit_index
);

  localparam int FI_W = (FIELD_W * FIELD_H > 1) ? $clog2(FIELD_W * FIELD_H) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;
  logic [CELLS-1:0]   blk_reg, blk_next;
  logic [POS_W-1:0]   pos_x_reg, pos_x_next;
  logic [POS_W-1:0]   pos_y_reg, pos_y_next;
  logic               collide_reg, collide_next;
  logic               oob_reg, oob_next;
  logic               ovl_reg, ovl_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;

  // Current cell geometry; one extra bit keeps the absolute position from wrapping.
  logic [POS_W:0]     b_x, b_y, abs_x, abs_y;
  logic [FI_W-1:0]    field_idx;
  logic               cell_set, cell_oob, cell_ovl, cell_hit, last_cell;

  always_comb begin
    b_x       = (POS_W+1)'(int'(cnt_reg) % BLK_N);
    b_y       = (POS_W+1)'(int'(cnt_reg) / BLK_N);
    abs_x     = {1'b0, pos_x_reg} + b_x;
    abs_y     = {1'b0, pos_y_reg} + b_y;
    cell_set  = blk_reg[cnt_reg];
    cell_oob  = cell_set && ((int'(abs_x) >= FIELD_W) || (int'(abs_y) >= FIELD_H));
    field_idx = '0;
    if (cell_set && !cell_oob)
      field_idx = FI_W'(int'(abs_y) * FIELD_W + int'(abs_x));
    cell_ovl  = cell_set && !cell_oob && field_matrix[field_idx];
    cell_hit  = cell_oob || cell_ovl;
    last_cell = (cnt_reg == IDX_W'(CELLS - 1));
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    blk_next     = blk_reg;
    pos_x_next   = pos_x_reg;
    pos_y_next   = pos_y_reg;
    collide_next = collide_reg;
    oob_next     = oob_reg;
    ovl_next     = ovl_reg;
    idx_next     = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          blk_next     = block_matrix;
          pos_x_next   = block_pos_x;
          pos_y_next   = block_pos_y;
          collide_next = 1'b0;
          oob_next     = 1'b0;
          ovl_next     = 1'b0;
          idx_next     = '0;
          cnt_next     = '0;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        if (cell_hit) begin
          oob_next = oob_reg | cell_oob;
          ovl_next = ovl_reg | cell_ovl;
          // Only the first colliding cell is reported as the index.
          if (!collide_reg) begin
            collide_next = 1'b1;
            idx_next     = cnt_reg;
          end
        end
        if (last_cell || ((EARLY_EXIT != 0) && cell_hit))
          state_next = DONE;
        else
          cnt_next = cnt_reg + 1'b1;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      blk_reg     <= '0;
      pos_x_reg   <= '0;
      pos_y_reg   <= '0;
      collide_reg <= 1'b0;
      oob_reg     <= 1'b0;
      ovl_reg     <= 1'b0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      blk_reg     <= blk_next;
      pos_x_reg   <= pos_x_next;
      pos_y_reg   <= pos_y_next;
      collide_reg <= collide_next;
      oob_reg     <= oob_next;
      ovl_reg     <= ovl_next;
      idx_reg     <= idx_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign collide     = collide_reg;
  assign hit_oob     = oob_reg;
  assign hit_overlap = ovl_reg;
  assign hit_index   = idx_reg;

endmodule

// File: tb/tb_block_scan_check.sv
// Bench for block_scan_check: directed vector table, multi-cycle corner sequences
// and randomized checks against a loop-based reference model, on two instances.
module tb_block_scan_check;

  localparam int FW = 20, FH = 20, BN = 4, PW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [PW-1:0]   pos_x = '0, pos_y = '0;
  logic [15:0]     shape = '0;
  logic [399:0]    field = '0;

  logic            busy_a, done_a, col_a, oob_a, ovl_a;
  logic [3:0]      idx_a;
  logic            busy_b, done_b, col_b, oob_b, ovl_b;
  logic [3:0]      idx_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // dut_a stops at the first hit, dut_b always scans every cell.
  block_scan_check #(.FIELD_W(FW), .FIELD_H(FH), .BLK_N(BN), .POS_W(PW), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .block_pos_x(pos_x), .block_pos_y(pos_y),
    .block_matrix(shape), .field_matrix(field), .busy(busy_a), .done(done_a),
    .collide(col_a), .hit_oob(oob_a), .hit_overlap(ovl_a), .hit_index(idx_a));

  block_scan_check #(.FIELD_W(FW), .FIELD_H(FH), .BLK_N(BN), .POS_W(PW), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .block_pos_x(pos_x), .block_pos_y(pos_y),
    .block_matrix(shape), .field_matrix(field), .busy(busy_b), .done(done_b),
    .collide(col_b), .hit_oob(oob_b), .hit_overlap(ovl_b), .hit_index(idx_b));

  typedef struct {
    int c, o, v, idx, lat;
  } res_t;

  typedef struct {
    logic [15:0] shp;
    int          px, py;
    int          fmode;   // 0 empty, 1 single occupied cell (fx,fy), 2 fully occupied
    int          fx, fy;
    int          ee;      // which instance is checked: 1 early-exit, 0 full-scan
    res_t        exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the shape cells in index order using plain integer geometry.
  function automatic res_t model(input logic [15:0] shp, input int px, input int py,
                                 input logic [399:0] fld, input int ee);
    res_t r;
    r = '{0, 0, 0, 0, BN * BN};
    for (int k = 0; k < BN * BN; k++) begin
      int x, y;
      bit out_f, over;
      if (!shp[k]) continue;
      x = px + k % BN;
      y = py + k / BN;
      out_f = (x >= FW) || (y >= FH);
      over  = !out_f && fld[y * FW + x];
      if (out_f || over) begin
        if (r.c == 0) begin
          r.c = 1;
          r.idx = k;
        end
        if (out_f) r.o = 1;
        if (over)  r.v = 1;
        if (ee != 0) begin
          r.lat = k + 1;
          return r;
        end
      end
    end
    return r;
  endfunction

  // Start one check on both instances; record the edge count to done and results.
  task automatic run(output res_t ra, output res_t rb);
    ra = '{0, 0, 0, 0, 0};
    rb = '{0, 0, 0, 0, 0};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy_a && busy_b), 1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a && ra.lat == 0) ra = '{int'(col_a), int'(oob_a), int'(ovl_a), int'(idx_a), n};
      if (done_b && rb.lat == 0) rb = '{int'(col_b), int'(oob_b), int'(ovl_b), int'(idx_b), n};
      if (ra.lat != 0 && rb.lat != 0) break;
    end
    @(negedge clk);
    check("hold_collide", int'(col_a), ra.c);
    check("hold_index", int'(idx_a), ra.idx);
    check("idle_after_done", int'(busy_a | busy_b | done_a | done_b), 0);
  endtask

  task automatic compare(input string tag, input res_t act, input res_t exp);
    check({tag, ".collide"}, act.c, exp.c);
    check({tag, ".hit_oob"}, act.o, exp.o);
    check({tag, ".hit_overlap"}, act.v, exp.v);
    check({tag, ".hit_index"}, act.idx, exp.idx);
    check({tag, ".latency"}, act.lat, exp.lat);
  endtask

  vec_t vecs[8];
  res_t ra, rb, ea, eb;
  int   lat;

  initial begin
    vecs[0] = '{16'h0072,  5,  5, 0,  0,  0, 1, '{0, 0, 0, 0, 16}};
    vecs[1] = '{16'h0072,  5,  5, 1,  6,  5, 1, '{1, 0, 1, 1, 2}};
    vecs[2] = '{16'h000F, 18,  0, 0,  0,  0, 1, '{1, 1, 0, 2, 3}};
    vecs[3] = '{16'h000F, 16,  0, 0,  0,  0, 1, '{0, 0, 0, 0, 16}};
    vecs[4] = '{16'h0001, 31, 31, 0,  0,  0, 1, '{1, 1, 0, 0, 1}};
    vecs[5] = '{16'h0033, 18, 19, 1, 18, 19, 0, '{1, 1, 1, 0, 16}};
    vecs[6] = '{16'h0033, 18, 19, 1, 18, 19, 1, '{1, 0, 1, 0, 1}};
    vecs[7] = '{16'h0000,  0,  0, 2,  0,  0, 0, '{0, 0, 0, 0, 16}};

    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy_a | busy_b), 0);
    check("rst.done", int'(done_a | done_b), 0);
    check("rst.flags", int'(col_a | oob_a | ovl_a | col_b | oob_b | ovl_b), 0);
    check("rst.index", int'(idx_a) + int'(idx_b), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      shape = vecs[i].shp;
      pos_x = PW'(vecs[i].px);
      pos_y = PW'(vecs[i].py);
      field = (vecs[i].fmode == 2) ? '1 : '0;
      if (vecs[i].fmode == 1) field[vecs[i].fy * FW + vecs[i].fx] = 1'b1;
      run(ra, rb);
      compare($sformatf("vec%0d", i), (vecs[i].ee != 0) ? ra : rb, vecs[i].exp);
      $display("vec%0d shape=%h pos=(%0d,%0d) ee=%0d collide=%0d idx=%0d lat=%0d", i,
               vecs[i].shp, vecs[i].px, vecs[i].py, vecs[i].ee,
               (vecs[i].ee != 0) ? ra.c : rb.c, (vecs[i].ee != 0) ? ra.idx : rb.idx,
               (vecs[i].ee != 0) ? ra.lat : rb.lat);
    end

    // Start while busy and start during the DONE cycle are both ignored.
    shape = 16'h0072; pos_x = 5; pos_y = 5; field = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    shape = 16'h0001; pos_x = 31; pos_y = 31;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    for (int n = 5; n <= 40; n++) begin
      @(negedge clk);
      if (done_a) begin
        lat = n;
        break;
      end
    end
    check("busy_start.latency", lat, 16);
    check("busy_start.collide", int'(col_a), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("done_start.busy", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    check("done_start.stable", int'(col_a | oob_a), 0);
    $display("ignored-start sequence latency=%0d collide=%0d", lat, col_a);

    // Reset in the middle of a scan: immediate idle, cleared results, no done.
    shape = 16'h0033; pos_x = 18; pos_y = 19; field = '0; field[19 * FW + 18] = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.busy", int'(busy_b), 0);
    check("midrst.collide", int'(col_b), 0);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_a || done_b || busy_b) lat = 1;
    end
    check("midrst.no_done", lat, 0);
    $display("mid-scan reset busy=%0d collide=%0d", busy_b, col_b);

    // Randomized shapes, positions and fields against the reference model.
    for (int t = 0; t < 40; t++) begin
      shape = 16'($urandom);
      if (t % 5 == 0) shape = 16'h0000;
      pos_x = PW'($urandom_range(0, 31));
      pos_y = PW'($urandom_range(0, 31));
      for (int i = 0; i < 400; i++) field[i] = ($urandom_range(0, 5) == 0);
      ea = model(shape, int'(pos_x), int'(pos_y), field, 1);
      eb = model(shape, int'(pos_x), int'(pos_y), field, 0);
      run(ra, rb);
      compare($sformatf("rnd%0d.ee1", t), ra, ea);
      compare($sformatf("rnd%0d.ee0", t), rb, eb);
      $display("rnd%0d shape=%h pos=(%0d,%0d) ee1 c=%0d i=%0d l=%0d ee0 c=%0d o=%0d v=%0d", t,
               shape, pos_x, pos_y, ra.c, ra.idx, ra.lat, rb.c, rb.o, rb.v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
